// File: rtl/encoder_pkg.sv
// Shared encodings for the RV32I instruction encoder: opcodes, ALU control codes,
// request classes and error codes.
package encoder_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Same codes the core's ALU control path decodes into.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        CLS_R      = 2'b00,
        CLS_I      = 2'b01,
        CLS_LOAD   = 2'b10,
        CLS_BRANCH = 2'b11
    } instr_class_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_ALU_OP    = 2'b01,
        ERR_IMM_RANGE = 2'b10,
        ERR_BR_ALIGN  = 2'b11
    } err_code_e;

    function automatic logic [2:0] alu_funct3(input logic [2:0] op);
        logic [2:0] f3;
        f3 = 3'b000;
        case (op)
            ALU_SLT: f3 = 3'b010;
            ALU_OR:  f3 = 3'b110;
            ALU_AND: f3 = 3'b111;
            default: f3 = 3'b000;
        endcase
        return f3;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-visible head; push is ignored when full.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push_i & ~full_o;
        pop_ok   = pop_i & ~empty_o;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes field-level requests into RV32I words, tags each with a byte address and
// queues {word, addr}; an illegal request halts intake until err_clear_i.
module instr_encoder
    import encoder_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [1:0]                 type_i,
    input  logic [2:0]                 alu_op_i,
    input  logic [4:0]                 rd_i,
    input  logic [4:0]                 rs1_i,
    input  logic [4:0]                 rs2_i,
    input  logic [31:0]                imm_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [31:0]                instr_o,
    output logic [31:0]                addr_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       err_o,
    output logic [1:0]                 err_code_o,
    input  logic                       err_clear_i
);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]   state_q, state_d;
    err_code_e    err_code_q, err_code_d;
    logic [31:0]  next_addr_q, next_addr_d;

    instr_class_e cls;
    logic         op_known;
    logic         imm12_ok, br_range_ok;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic [31:0]  enc_word;
    err_code_e    enc_err;
    logic         accept, push, pop;

    logic         fifo_full, fifo_empty;
    logic [63:0]  fifo_head;
    logic [CW-1:0] fifo_count;

    always_comb begin
        cls         = instr_class_e'(type_i);
        funct3      = alu_funct3(alu_op_i);
        funct7      = (alu_op_i == ALU_SUB) ? 7'b0100000 : 7'b0000000;
        imm12_ok    = ($signed(imm_i) >= -32'sd2048) && ($signed(imm_i) <= 32'sd2047);
        br_range_ok = ($signed(imm_i) >= -32'sd4096) && ($signed(imm_i) <= 32'sd4094);
        op_known    = (alu_op_i == ALU_ADD) || (alu_op_i == ALU_SUB) || (alu_op_i == ALU_AND)
                   || (alu_op_i == ALU_OR)  || (alu_op_i == ALU_SLT);

        enc_word = NOP;
        enc_err  = ERR_NONE;
        // Checks run in priority order: bad op, then range, then branch alignment.
        unique case (cls)
            CLS_R: begin
                enc_word = {funct7, rs2_i, rs1_i, funct3, rd_i, OP_R};
                if (!op_known) enc_err = ERR_ALU_OP;
            end
            CLS_I: begin
                enc_word = {imm_i[11:0], rs1_i, funct3, rd_i, OP_IMM};
                if (!op_known || alu_op_i == ALU_SUB) enc_err = ERR_ALU_OP;
                else if (!imm12_ok)                   enc_err = ERR_IMM_RANGE;
            end
            CLS_LOAD: begin
                enc_word = {imm_i[11:0], rs1_i, 3'b010, rd_i, OP_LOAD};
                if (!imm12_ok) enc_err = ERR_IMM_RANGE;
            end
            CLS_BRANCH: begin
                enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 3'b000,
                            imm_i[4:1], imm_i[11], OP_BRANCH};
                if (!br_range_ok)  enc_err = ERR_IMM_RANGE;
                else if (imm_i[0]) enc_err = ERR_BR_ALIGN;
            end
            default: enc_err = ERR_NONE;
        endcase
    end

    assign in_ready_o = (state_q == ST_RUN) & ~fifo_full;
    assign accept     = in_valid_i & in_ready_o;
    assign push       = accept & (enc_err == ERR_NONE);
    assign pop        = out_valid_o & out_ready_i;

    always_comb begin
        state_d     = state_q;
        err_code_d  = err_code_q;
        next_addr_d = push ? next_addr_q + 32'd4 : next_addr_q;
        case (state_q)
            ST_RUN: begin
                if (accept && enc_err != ERR_NONE) begin
                    state_d    = ST_HALT;
                    err_code_d = enc_err;
                end
            end
            default: begin
                if (err_clear_i) begin
                    state_d    = ST_RUN;
                    err_code_d = ERR_NONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            err_code_q  <= ERR_NONE;
            next_addr_q <= BASE_ADDR;
        end else begin
            state_q     <= state_d;
            err_code_q  <= err_code_d;
            next_addr_q <= next_addr_d;
        end
    end

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  ({enc_word, next_addr_q}),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_valid_o = ~fifo_empty;
    assign instr_o     = fifo_empty ? NOP : fifo_head[63:32];
    assign addr_o      = fifo_empty ? 32'h0 : fifo_head[31:0];
    assign count_o     = fifo_count;
    assign err_o       = (state_q == ST_HALT);
    assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized checks of instr_encoder against an arithmetic reference
// model of the RV32I encoding rules and a queue model of the output buffer.
module tb_instr_encoder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i, in_ready_o;
    logic [1:0]  type_i;
    logic [2:0]  alu_op_i;
    logic [4:0]  rd_i, rs1_i, rs2_i;
    logic [31:0] imm_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] instr_o, addr_o;
    logic [2:0]  count_o;
    logic        err_o;
    logic [1:0]  err_code_o;
    logic        err_clear_i;

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .type_i      (type_i),
        .alu_op_i    (alu_op_i),
        .rd_i        (rd_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .imm_i       (imm_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .instr_o     (instr_o),
        .addr_o      (addr_o),
        .count_o     (count_o),
        .err_o       (err_o),
        .err_code_o  (err_code_o),
        .err_clear_i (err_clear_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] w;
        logic [31:0] a;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_addr;
    bit          m_halt;
    int          m_code;
    int          n_vec  = 0;
    int          n_miss = 0;
    int          n_req  = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint sh(input int v, input int n);
        return longint'(v) << n;
    endfunction

    // Reference encoding built from field arithmetic; err is 0 for legal, else the code.
    function automatic logic [31:0] ref_word(input int typ, input int op, input int rd,
                                             input int rs1, input int rs2, input int imm,
                                             output int err);
        int     f3_tab[8] = '{0, 0, 7, 6, 0, 2, 0, 0};
        bit     op_ok;
        int     u, f3;
        longint w;
        op_ok = (op == 0 || op == 1 || op == 2 || op == 3 || op == 5);
        f3    = f3_tab[op];
        err   = 0;
        w     = 0;
        if (typ == 0 && !op_ok)                                   err = 1;
        else if (typ == 1 && (!op_ok || op == 1))                 err = 1;
        else if ((typ == 1 || typ == 2) && (imm < -2048 || imm > 2047)) err = 2;
        else if (typ == 3 && (imm < -4096 || imm > 4094))         err = 2;
        else if (typ == 3 && (imm % 2) != 0)                      err = 3;
        case (typ)
            0: w = sh((op == 1) ? 32 : 0, 25) + sh(rs2, 20) + sh(rs1, 15) + sh(f3, 12) + sh(rd, 7) + 51;
            1: w = sh(((imm % 4096) + 4096) % 4096, 20) + sh(rs1, 15) + sh(f3, 12) + sh(rd, 7) + 19;
            2: w = sh(((imm % 4096) + 4096) % 4096, 20) + sh(rs1, 15) + sh(2, 12) + sh(rd, 7) + 3;
            default: begin
                u = ((imm % 8192) + 8192) % 8192;
                w = sh(u / 4096, 31) + sh((u / 32) % 64, 25) + sh(rs2, 20) + sh(rs1, 15)
                  + sh((u / 2) % 16, 8) + sh((u / 2048) % 2, 7) + 99;
            end
        endcase
        return w[31:0];
    endfunction

    task automatic check_outputs();
        bit ne = (mq.size() != 0);
        check_value("out_valid", 32'(out_valid_o), 32'(ne));
        check_value("instr", instr_o, ne ? mq[0].w : 32'h0000_0013);
        check_value("addr", addr_o, ne ? mq[0].a : 32'h0);
        check_value("count", 32'(count_o), 32'(mq.size()));
        check_value("in_ready", 32'(in_ready_o), 32'(!m_halt && mq.size() < DEPTH));
        check_value("err", 32'(err_o), 32'(m_halt));
        check_value("err_code", 32'(err_code_o), 32'(m_code));
    endtask

    task automatic drive(input bit v, input int typ, input int op, input int rd, input int rs1,
                         input int rs2, input int imm, input bit ordy, input bit clr);
        in_valid_i  = v;
        type_i      = 2'(typ);
        alu_op_i    = 3'(op);
        rd_i        = 5'(rd);
        rs1_i       = 5'(rs1);
        rs2_i       = 5'(rs2);
        imm_i       = 32'(imm);
        out_ready_i = ordy;
        err_clear_i = clr;
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, 0, 0, 0, 0, 0, 0, ordy, 1'b0);
    endtask

    // One clock: advance the model with the inputs present at the edge, then check.
    task automatic tick();
        bit          acc, pop, was_halt;
        int          e;
        logic [31:0] w;
        ent_t        ent;
        @(posedge clk_i);
        acc      = in_valid_i && !m_halt && mq.size() < DEPTH;
        pop      = (mq.size() != 0) && out_ready_i;
        was_halt = m_halt;
        w = ref_word(int'(type_i), int'(alu_op_i), int'(rd_i), int'(rs1_i), int'(rs2_i),
                     int'($signed(imm_i)), e);
        if (pop) void'(mq.pop_front());
        if (acc) begin
            n_req++;
            $display("req %0d: type %0d op %0d imm %0d -> word %h addr %h err %0d",
                     n_req, type_i, alu_op_i, $signed(imm_i), w, m_addr, e);
            if (e == 0) begin
                ent.w = w;
                ent.a = m_addr;
                mq.push_back(ent);
                m_addr = m_addr + 32'd4;
            end else begin
                m_halt = 1'b1;
                m_code = e;
            end
        end
        if (was_halt && err_clear_i) begin
            m_halt = 1'b0;
            m_code = 0;
        end
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        idle(1'b0);
        #1;
        mq.delete();
        m_addr = BASE;
        m_halt = 1'b0;
        m_code = 0;
        check_value("rst_count", 32'(count_o), 32'd0);
        check_value("rst_valid", 32'(out_valid_o), 32'd0);
        check_value("rst_instr", instr_o, 32'h0000_0013);
        check_value("rst_addr", addr_o, 32'h0);
        check_value("rst_err", 32'(err_o), 32'd0);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_outputs();
    endtask

    initial begin
        int typ, imm, sel;
        int bnd[10] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4097, -4095, 4096};
        rst_ni = 1'b1;
        idle(1'b0);
        do_reset();
        check_value("rst_ready", 32'(in_ready_o), 32'd1);

        drive(1'b1, 0, 0, 3, 1, 2, 0, 1'b0, 1'b0); tick();
        idle(1'b0);
        check_value("r_add_word", instr_o, 32'h002081B3);
        check_value("r_add_addr", addr_o, 32'h0);

        do_reset();
        drive(1'b1, 0, 1, 5, 6, 7, 0, 1'b1, 1'b0); tick();
        check_value("r_sub_word", instr_o, 32'h407302B3);
        drive(1'b1, 1, 0, 1, 0, 0, -1, 1'b1, 1'b0); tick();
        check_value("i_add_word", instr_o, 32'hFFF00093);
        check_value("i_add_addr", addr_o, 32'h4);
        drive(1'b1, 2, 0, 2, 1, 0, 8, 1'b1, 1'b0); tick();
        check_value("lw_word", instr_o, 32'h0080A103);
        check_value("lw_addr", addr_o, 32'h8);

        do_reset();
        drive(1'b1, 3, 0, 9, 1, 2, -8, 1'b0, 1'b0); tick();
        check_value("beq_word", instr_o, 32'hFE208CE3);
        drive(1'b1, 3, 0, 0, 1, 2, -7, 1'b0, 1'b0); tick();
        idle(1'b0);
        check_value("beq_mis_code", 32'(err_code_o), 32'd3);
        check_value("beq_mis_count", 32'(count_o), 32'd1);
        drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1); tick();

        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 0, 0, i + 1, 1, 2, 0, 1'b0, 1'b0); tick();
        end
        idle(1'b0);
        check_value("full_count", 32'(count_o), 32'd4);
        check_value("full_ready", 32'(in_ready_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_value("drain_addr", addr_o, 32'(4 * i));
            idle(1'b1); tick();
        end

        do_reset();
        drive(1'b1, 1, 0, 1, 1, 0, 2048, 1'b0, 1'b0); tick();
        check_value("imm_rng_code", 32'(err_code_o), 32'd2);
        check_value("imm_rng_ready", 32'(in_ready_o), 32'd0);
        drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1); tick();
        drive(1'b1, 1, 2, 1, 1, 0, 5, 1'b0, 1'b0); tick();
        check_value("post_clr_addr", addr_o, 32'h0);
        drive(1'b1, 1, 1, 1, 1, 0, 5, 1'b0, 1'b0); tick();
        check_value("i_sub_code", 32'(err_code_o), 32'd1);
        drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1); tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2, 0, 4, 4, 0, 16 * i, 1'b0, 1'b0); tick();
        end
        check_value("pre_rst_count", 32'(count_o), 32'd3);
        do_reset();
        drive(1'b1, 0, 5, 7, 8, 9, 0, 1'b0, 1'b0); tick();
        check_value("post_rst_addr", addr_o, BASE);

        for (int n = 0; n < 1500; n++) begin
            typ = int'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 9));
            if (sel < 5)       imm = int'($urandom_range(0, 400)) - 200;
            else if (sel < 7)  imm = bnd[$urandom_range(0, 9)];
            else if (sel == 7) imm = int'($urandom);
            else               imm = 2 * (int'($urandom_range(0, 4094)) - 2048);
            drive($urandom_range(0, 9) < 7, typ, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), imm, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 4) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
